// File: rtl/idli_sqi_ctrl_m_if.sv
`default_nettype none
// ============================================================================
//  Module   : idli_sqi_ctrl_m_if
//  Purpose  : Core, IO-register and SQI memory signals of the SQI sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface idli_sqi_ctrl_m_if;
  logic       i_sqi_req;
  logic       i_sqi_wr;
  logic       i_sqi_seq;
  logic [15:0] i_sqi_addr;
  logic       o_sqi_busy;
  logic       o_sqi_done;
  logic [3:0] i_sqi_core_data;
  logic       i_sqi_core_wr_en;
  logic [3:0] o_sqi_reg_data;
  logic       o_sqi_reg_wr_en;
  logic [3:0] i_sqi_reg_data;
  logic       o_sqi_mem_cs_n;
  logic       o_sqi_mem_sck_en;
  logic [3:0] o_sqi_mem_sio;
  logic       o_sqi_mem_oe;
  logic [3:0] i_sqi_mem_sio;

  modport slave (
    input  i_sqi_req, i_sqi_wr, i_sqi_seq, i_sqi_addr,
    input  i_sqi_core_data, i_sqi_core_wr_en, i_sqi_reg_data, i_sqi_mem_sio,
    output o_sqi_busy, o_sqi_done, o_sqi_reg_data, o_sqi_reg_wr_en,
    output o_sqi_mem_cs_n, o_sqi_mem_sck_en, o_sqi_mem_sio, o_sqi_mem_oe
  );

  modport master (
    output i_sqi_req, i_sqi_wr, i_sqi_seq, i_sqi_addr,
    output i_sqi_core_data, i_sqi_core_wr_en, i_sqi_reg_data, i_sqi_mem_sio,
    input  o_sqi_busy, o_sqi_done, o_sqi_reg_data, o_sqi_reg_wr_en,
    input  o_sqi_mem_cs_n, o_sqi_mem_sck_en, o_sqi_mem_sio, o_sqi_mem_oe
  );
endinterface
`default_nettype wire

// File: rtl/idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module   : idli_sqi_ctrl_m
//  Purpose  : SQI SRAM transaction sequencer in front of the nibble IO register.
//  Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_ctrl_m #(
  parameter logic [7:0] CMD_RD        = 8'h03,
  parameter logic [7:0] CMD_WR        = 8'h02,
  parameter int         DUMMY_NIBBLES = 2
) (
  input  logic               i_sqi_gck,
  input  logic               i_sqi_rst,
  idli_sqi_ctrl_m_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [1:0] C_DUMMY_LAST = 2'(DUMMY_NIBBLES - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_addr;
  logic        r_wr;
  logic        r_cs_n;
  logic        r_sck_en;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_opcode;
  logic [3:0]  w_reg_data;
  logic        w_reg_wr_en;
  logic [3:0]  w_mem_sio;

  // Pin controls are registered against the state being entered so they line up with it.
  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_addr   <= 16'h0000;
      r_wr     <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sck_en <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + 2'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 2'd0;
          if (bus.i_sqi_req) begin
            r_state  <= S_CMD;
            r_addr   <= bus.i_sqi_addr;
            r_wr     <= bus.i_sqi_wr;
            r_cs_n   <= 1'b0;
            r_sck_en <= 1'b1;
            r_oe     <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_CMD: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_ADDR;
            r_cnt   <= 2'd0;
          end
        end
        S_ADDR: begin
          if (r_cnt == 2'd3) begin
            r_cnt <= 2'd0;
            if (r_wr) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_DUMMY;
              r_oe    <= 1'b0;
            end
          end
        end
        S_DUMMY: begin
          if (r_cnt == C_DUMMY_LAST) begin
            r_state <= S_DATA;
            r_cnt   <= 2'd0;
          end
        end
        S_DATA: begin
          if (r_cnt == 2'd3) begin
            r_done <= 1'b1;
            r_cnt  <= 2'd0;
            if (!(bus.i_sqi_req && bus.i_sqi_seq && (bus.i_sqi_wr == r_wr))) begin
              r_state  <= S_END;
              r_cs_n   <= 1'b1;
              r_sck_en <= 1'b0;
              r_oe     <= 1'b0;
            end
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 2'd0;
          r_cs_n   <= 1'b1;
          r_sck_en <= 1'b0;
          r_oe     <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign w_opcode = r_wr ? CMD_WR : CMD_RD;

  // Nibble steering between core, IO register and memory pins.
  always_comb begin
    w_reg_data  = bus.i_sqi_reg_data;
    w_reg_wr_en = 1'b0;
    w_mem_sio   = 4'h0;
    case (r_state)
      S_IDLE: begin
        w_reg_data  = bus.i_sqi_core_data;
        w_reg_wr_en = bus.i_sqi_core_wr_en;
      end
      S_CMD: begin
        w_mem_sio = (r_cnt == 2'd0) ? w_opcode[7:4] : w_opcode[3:0];
      end
      S_ADDR: begin
        case (r_cnt)
          2'd0:    w_mem_sio = r_addr[15:12];
          2'd1:    w_mem_sio = r_addr[11:8];
          2'd2:    w_mem_sio = r_addr[7:4];
          default: w_mem_sio = r_addr[3:0];
        endcase
      end
      S_DATA: begin
        if (r_wr) begin
          w_mem_sio = bus.i_sqi_reg_data;
        end else begin
          w_reg_wr_en = 1'b1;
          w_reg_data  = bus.i_sqi_mem_sio;
        end
      end
      default: begin
        w_mem_sio = 4'h0;
      end
    endcase
  end

  assign bus.o_sqi_busy       = r_busy;
  assign bus.o_sqi_done       = r_done;
  assign bus.o_sqi_reg_data   = w_reg_data;
  assign bus.o_sqi_reg_wr_en  = w_reg_wr_en;
  assign bus.o_sqi_mem_cs_n   = r_cs_n;
  assign bus.o_sqi_mem_sck_en = r_sck_en;
  assign bus.o_sqi_mem_sio    = w_mem_sio;
  assign bus.o_sqi_mem_oe     = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idli_sqi_ctrl_m
//  Purpose  : Directed and randomized transactions against a phase-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_ctrl_m;

  localparam int DUMMY = 2;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  idli_sqi_ctrl_m_if sqi_if ();

  idli_sqi_ctrl_m #(
    .CMD_RD        (8'h03),
    .CMD_WR        (8'h02),
    .DUMMY_NIBBLES (DUMMY)
  ) u_dut (
    .i_sqi_gck (clk),
    .i_sqi_rst (rst),
    .bus       (sqi_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // One entry per cycle after the accept edge: what the pins must show and what the bench drives.
  typedef struct {
    logic       cs_n, sck, oe, busy, done, wen;
    logic [3:0] sio, rdat, mem_in, reg_in;
    bit         sio_chk, rdat_chk, last_nib;
    int         word;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t base();
    exp_t e;
    e.cs_n = 1'b0; e.sck = 1'b1; e.oe = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.wen = 1'b0;
    e.sio = 4'h0; e.rdat = 4'h0; e.mem_in = 4'($urandom); e.reg_in = 4'($urandom);
    e.sio_chk = 1'b0; e.rdat_chk = 1'b0; e.last_nib = 1'b0; e.word = 0;
    return e;
  endfunction

  task automatic build(input bit wr, input logic [15:0] addr, input int n,
                       input logic [2:0][15:0] dat);
    exp_t       e;
    logic [7:0] op;
    logic [3:0] nib;
    q.delete();
    op = wr ? 8'h02 : 8'h03;
    e = base(); e.sio = op[7:4]; e.sio_chk = 1'b1; q.push_back(e);
    e = base(); e.sio = op[3:0]; e.sio_chk = 1'b1; q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      e = base(); e.sio = addr[15-4*i -: 4]; e.sio_chk = 1'b1; q.push_back(e);
    end
    if (!wr) begin
      for (int i = 0; i < DUMMY; i++) begin
        e = base(); e.oe = 1'b0; e.sio = 4'h0; e.sio_chk = 1'b1; q.push_back(e);
      end
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        e = base();
        nib = dat[w][15-4*k -: 4];
        e.word = w; e.last_nib = (k == 3); e.done = (w > 0 && k == 0);
        if (wr) begin
          e.oe = 1'b1; e.sio = nib; e.sio_chk = 1'b1; e.reg_in = nib;
        end else begin
          e.oe = 1'b0; e.wen = 1'b1; e.mem_in = nib; e.rdat = nib; e.rdat_chk = 1'b1;
        end
        q.push_back(e);
      end
    end
    e = base(); e.cs_n = 1'b1; e.sck = 1'b0; e.oe = 1'b0; e.done = 1'b1; q.push_back(e);
  endtask

  task automatic drive_core();
    sqi_if.i_sqi_core_data  = 4'($urandom);
    sqi_if.i_sqi_core_wr_en = 1'($urandom);
  endtask

  task automatic run_txn(input bit wr, input logic [15:0] addr, input int n,
                         input logic [2:0][15:0] dat,
                         input bit nreq, input bit nseq, input bit nwr);
    int cs_low;
    int first_done;
    build(wr, addr, n, dat);
    @(posedge clk); #1;
    sqi_if.i_sqi_req  = 1'b1;
    sqi_if.i_sqi_wr   = wr;
    sqi_if.i_sqi_addr = addr;
    sqi_if.i_sqi_seq  = 1'($urandom);
    drive_core();
    #1;
    chk("idle_busy", 16'(sqi_if.o_sqi_busy), 16'd0);
    chk("idle_cs_n", 16'(sqi_if.o_sqi_mem_cs_n), 16'd1);
    chk("idle_pass_wen", 16'(sqi_if.o_sqi_reg_wr_en), 16'(sqi_if.i_sqi_core_wr_en));
    cs_low = 0;
    first_done = 0;
    for (int c = 0; c < q.size(); c++) begin
      @(posedge clk); #1;
      sqi_if.i_sqi_mem_sio  = q[c].mem_in;
      sqi_if.i_sqi_reg_data = q[c].reg_in;
      sqi_if.i_sqi_addr     = 16'($urandom);
      drive_core();
      if (q[c].last_nib && q[c].word < n - 1) begin
        sqi_if.i_sqi_req = 1'b1; sqi_if.i_sqi_seq = 1'b1; sqi_if.i_sqi_wr = wr;
      end else if (q[c].last_nib || c == q.size() - 1) begin
        sqi_if.i_sqi_req = nreq; sqi_if.i_sqi_seq = nseq; sqi_if.i_sqi_wr = nwr;
      end else begin
        sqi_if.i_sqi_req = 1'($urandom); sqi_if.i_sqi_seq = 1'($urandom);
        sqi_if.i_sqi_wr  = 1'($urandom);
      end
      #1;
      chk("cs_n",   16'(sqi_if.o_sqi_mem_cs_n),   16'(q[c].cs_n));
      chk("sck_en", 16'(sqi_if.o_sqi_mem_sck_en), 16'(q[c].sck));
      chk("oe",     16'(sqi_if.o_sqi_mem_oe),     16'(q[c].oe));
      chk("busy",   16'(sqi_if.o_sqi_busy),       16'(q[c].busy));
      chk("done",   16'(sqi_if.o_sqi_done),       16'(q[c].done));
      chk("reg_wr_en", 16'(sqi_if.o_sqi_reg_wr_en), 16'(q[c].wen));
      if (q[c].sio_chk)  chk("mem_sio",  16'(sqi_if.o_sqi_mem_sio),  16'(q[c].sio));
      if (q[c].rdat_chk) chk("reg_data", 16'(sqi_if.o_sqi_reg_data), 16'(q[c].rdat));
      if (sqi_if.o_sqi_mem_cs_n === 1'b0) cs_low++;
      if (sqi_if.o_sqi_done === 1'b1 && first_done == 0) first_done = c + 1;
    end
    chk("cs_low_cycles", 16'(cs_low), 16'(6 + (wr ? 0 : DUMMY) + 4 * n));
    chk("done_latency", 16'(first_done), 16'(2 + 4 + (wr ? 0 : DUMMY) + 4 + 1));
  endtask

  initial begin
    logic [2:0][15:0] d;
    bit               nreq;
    bit               nwr;
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    sqi_if.i_sqi_req = 1'b0; sqi_if.i_sqi_wr = 1'b0; sqi_if.i_sqi_seq = 1'b0;
    sqi_if.i_sqi_addr = 16'h0000; sqi_if.i_sqi_core_data = 4'h0;
    sqi_if.i_sqi_core_wr_en = 1'b0; sqi_if.i_sqi_reg_data = 4'h0;
    sqi_if.i_sqi_mem_sio = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n",   16'(sqi_if.o_sqi_mem_cs_n),   16'd1);
    chk("rst_sck_en", 16'(sqi_if.o_sqi_mem_sck_en), 16'd0);
    chk("rst_oe",     16'(sqi_if.o_sqi_mem_oe),     16'd0);
    chk("rst_sio",    16'(sqi_if.o_sqi_mem_sio),    16'd0);
    chk("rst_busy",   16'(sqi_if.o_sqi_busy),       16'd0);
    chk("rst_done",   16'(sqi_if.o_sqi_done),       16'd0);
    rst = 1'b0;

    // Idle pass-through
    @(posedge clk); #1;
    sqi_if.i_sqi_core_data = 4'h9; sqi_if.i_sqi_core_wr_en = 1'b1;
    #1;
    chk("pass_wen",  16'(sqi_if.o_sqi_reg_wr_en), 16'd1);
    chk("pass_data", 16'(sqi_if.o_sqi_reg_data),  16'h9);
    chk("pass_cs_n", 16'(sqi_if.o_sqi_mem_cs_n),  16'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_core();
      #1;
      chk("pass_rand_data", 16'(sqi_if.o_sqi_reg_data),  16'(sqi_if.i_sqi_core_data));
      chk("pass_rand_wen",  16'(sqi_if.o_sqi_reg_wr_en), 16'(sqi_if.i_sqi_core_wr_en));
    end
    sqi_if.i_sqi_core_wr_en = 1'b0;

    run_txn(1'b0, 16'h1234, 1, {16'h0, 16'h0, 16'hABCD}, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 16'hBEEF, 1, {16'h0, 16'h0, 16'h5678}, 1'b0, 1'b0, 1'b0);

    d = {16'($urandom), 16'($urandom), 16'($urandom)};
    run_txn(1'b0, 16'($urandom), 3, d, 1'b0, 1'b0, 1'b0);

    // Back-to-back with seq=0, then a direction change with seq=1
    d = {16'($urandom), 16'($urandom), 16'($urandom)};
    run_txn(1'b0, 16'h4000, 1, d, 1'b1, 1'b0, 1'b1);
    run_txn(1'b1, 16'h8002, 1, d, 1'b1, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0C0E, 2, d, 1'b1, 1'b1, 1'b1);
    run_txn(1'b1, 16'h5A5A, 1, d, 1'b0, 1'b0, 1'b0);

    // Reset during the second address nibble
    @(posedge clk); #1;
    sqi_if.i_sqi_req = 1'b1; sqi_if.i_sqi_wr = 1'b0; sqi_if.i_sqi_addr = 16'h7777;
    repeat (3) begin
      @(posedge clk); #1;
      sqi_if.i_sqi_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("addr2_cs_n", 16'(sqi_if.o_sqi_mem_cs_n), 16'd0);
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 16'(sqi_if.o_sqi_mem_cs_n), 16'd1);
    chk("arst_busy", 16'(sqi_if.o_sqi_busy),     16'd0);
    chk("arst_done", 16'(sqi_if.o_sqi_done),     16'd0);
    chk("arst_sck",  16'(sqi_if.o_sqi_mem_sck_en), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(1'b0, 16'h2468, 1, {16'h0, 16'h0, 16'h1357}, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      d    = {16'($urandom), 16'($urandom), 16'($urandom)};
      nreq = 1'($urandom);
      nwr  = 1'($urandom);
      run_txn(1'($urandom), 16'($urandom), int'($urandom_range(1, 3)), d,
              nreq, 1'($urandom), nwr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
